// File: rtl/pipe_perf_monitor_pkg.sv
// Shared types and constants for the pipeline performance monitor:
// run-control states, readout select codes and default widths.
package pipe_perf_monitor_pkg;

  localparam int DEF_CNT_W = 32;
  localparam int DEF_PC_W  = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [1:0] SEL_CYCLE = 2'd0;
  localparam logic [1:0] SEL_STALL = 2'd1;
  localparam logic [1:0] SEL_FLUSH = 2'd2;
  localparam logic [1:0] SEL_PC    = 2'd3;

endpackage

// File: rtl/pipe_perf_monitor_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module pipe_perf_monitor_sat_counter
  import pipe_perf_monitor_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] cnt_o
);

  // NOTE: sequential state is written with non-blocking assignments so every
  // flop in the design samples pre-edge values regardless of block order.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_o <= '0;
    end else if (clr_i) begin
      cnt_o <= '0;
    end else if (inc_i && (cnt_o != '1)) begin
      cnt_o <= cnt_o + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pipe_perf_monitor.sv
// Counts run cycles, hazard stalls and redirect flushes of a CPU run, captures the
// last redirect PC, and serves registered single-cycle readouts.
module pipe_perf_monitor
  import pipe_perf_monitor_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W,
  parameter int PC_W  = DEF_PC_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             clear_i,
  input  logic [CNT_W-1:0] cycle_limit_i,
  input  logic             stall_i,
  input  logic             jump_i,
  input  logic             branch_i,
  input  logic             branch_eq_i,
  input  logic [PC_W-1:0]  pc_i,
  input  logic             rd_req_i,
  input  logic [1:0]       rd_sel_i,
  output logic [CNT_W-1:0] rd_data_o,
  output logic             rd_valid_o,
  output logic             running_o,
  output logic             done_o
);

  state_e           state_q, state_d;
  logic             sample;
  logic             stall_ev;
  logic             redirect_ev;
  logic             limit_hit;
  logic             pending_q;
  logic [PC_W-1:0]  redir_pc_q;
  logic [CNT_W-1:0] cycle_cnt, stall_cnt, flush_cnt;
  logic [CNT_W-1:0] pc_ext;
  logic [CNT_W-1:0] rd_mux;

  // Events only count in RUN while the CPU is enabled.
  assign sample      = (state_q == ST_RUN) && start_i;
  assign stall_ev    = stall_i && !jump_i && !branch_i;
  assign redirect_ev = jump_i || (branch_i && branch_eq_i);
  // The increment wraps to zero at saturation, which never equals a non-zero limit.
  assign limit_hit   = sample && (cycle_limit_i != '0) &&
                       ((cycle_cnt + CNT_W'(1)) == cycle_limit_i);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (clear_i) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (start_i)   state_d = ST_RUN;
        ST_RUN:  if (limit_hit) state_d = ST_DONE;
        ST_DONE: state_d = ST_DONE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    running_o = (state_q == ST_RUN);
    done_o    = (state_q == ST_DONE);
  end

  // A redirect raises pending for exactly one cycle; the flush counter consumes it next edge.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      pending_q  <= 1'b0;
      redir_pc_q <= '0;
    end else if (clear_i) begin
      pending_q  <= 1'b0;
      redir_pc_q <= '0;
    end else begin
      pending_q <= sample && redirect_ev;
      if (sample && redirect_ev) begin
        redir_pc_q <= pc_i;
      end
    end
  end

  pipe_perf_monitor_sat_counter #(.CNT_W(CNT_W)) u_cycle_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (sample),
    .clr_i (clear_i),
    .cnt_o (cycle_cnt)
  );

  pipe_perf_monitor_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (sample && stall_ev),
    .clr_i (clear_i),
    .cnt_o (stall_cnt)
  );

  pipe_perf_monitor_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (pending_q),
    .clr_i (clear_i),
    .cnt_o (flush_cnt)
  );

  assign pc_ext = CNT_W'(redir_pc_q);

  always_comb begin
    // NOTE: assigning a default before the case keeps every path driven, so no latch is inferred.
    rd_mux = cycle_cnt;
    case (rd_sel_i)
      SEL_CYCLE: rd_mux = cycle_cnt;
      SEL_STALL: rd_mux = stall_cnt;
      SEL_FLUSH: rd_mux = flush_cnt;
      SEL_PC:    rd_mux = pc_ext;
      default:   rd_mux = cycle_cnt;
    endcase
  end

  // Readout captures pre-update values, so a read coincident with clear returns pre-clear data.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rd_data_o  <= '0;
      rd_valid_o <= 1'b0;
    end else begin
      rd_valid_o <= rd_req_i;
      if (rd_req_i) begin
        rd_data_o <= rd_mux;
      end
    end
  end

endmodule

// File: doc/pipe_perf_monitor.md
PIPE_PERF_MONITOR -- requirements
Module: pipe_perf_monitor

Interface
REQ-001 Parameter CNT_W, default 32: width of every event counter.
REQ-002 Parameter PC_W, default 32: width of the captured redirect PC.
REQ-003 clk_i  input  1  single clock; all state updates on rising edge.
REQ-004 rst_i  input  1  reset, asynchronous, active-low.
REQ-005 start_i  input  1  CPU run enable; events sampled only while high.
REQ-006 clear_i  input  1  synchronous clear of counters and state machine.
REQ-007 cycle_limit_i  input  CNT_W  run length in sampled cycles; 0 = unbounded.
REQ-008 stall_i  input  1  hazard-unit stall request for the current cycle.
REQ-009 jump_i  input  1  decode-stage jump.
REQ-010 branch_i  input  1  decode-stage branch.
REQ-011 branch_eq_i  input  1  branch comparator equal result.
REQ-012 pc_i  input  PC_W  current PC register value.
REQ-013 rd_req_i  input  1  readout request pulse.
REQ-014 rd_sel_i  input  2  readout select: 0 cycles, 1 stalls, 2 flushes, 3 last redirect PC.
REQ-015 rd_data_o  output  CNT_W  readout data; PC zero-extended or truncated to CNT_W.
REQ-016 rd_valid_o  output  1  one-cycle pulse qualifying rd_data_o.
REQ-017 running_o  output  1  high in RUN state.
REQ-018 done_o  output  1  high in DONE state.

Function
REQ-019 States IDLE, RUN, DONE; IDLE->RUN when start_i=1; RUN->DONE on the cycle the cycle counter reaches cycle_limit_i (limit != 0); DONE->IDLE only on clear_i.
REQ-020 In RUN with start_i=1, cycle counter increments by 1 per cycle; with start_i=0, state stays RUN and no event is sampled.
REQ-021 Stall event = stall_i & ~jump_i & ~branch_i; counted in the same cycle it is sampled.
REQ-022 Redirect event = jump_i | (branch_i & branch_eq_i); sets a pending flag and captures pc_i into the redirect-PC register.
REQ-023 Pending flag increments the flush counter exactly one cycle after the redirect, then clears; back-to-back redirects count one flush each.
REQ-024 A pending flush raised in the final RUN cycle is still committed in the first DONE cycle; no new events are sampled in IDLE or DONE.
REQ-025 All counters saturate at all-ones; no wrap.
REQ-026 clear_i has priority over every other event: zeroes counters, pending flag, redirect PC, forces IDLE next cycle.
REQ-027 rd_req_i sampled in any state; rd_data_o/rd_valid_o registered, valid one cycle after request, value as of the request cycle (pre-update).
REQ-028 rd_data_o holds last read value when rd_valid_o is low.
REQ-029 Simultaneous rd_req_i and clear_i returns pre-clear value.

Reset
REQ-030 While rst_i=0: state IDLE, all counters, pending flag, redirect PC, rd_data_o = 0; rd_valid_o, running_o, done_o = 0.
REQ-031 Reset asserted mid-RUN aborts immediately; no pending flush survives reset.

Structure
REQ-032 Shared package holds state enum, rd_sel encodings (SEL_CYCLE, SEL_STALL, SEL_FLUSH, SEL_PC), default widths.
REQ-033 One sub-module natural: sat_counter (CNT_W, inc, clr, saturating), instantiated three times.

Verification
REQ-034 limit=10, start_i=1, no events -> done_o high after 10 sampled cycles, cycle count reads 10, stalls/flushes 0.
REQ-035 stall_i high 3 cycles, one with branch_i=1 -> stall count 2.
REQ-036 jump_i pulse at pc_i=0x0000_0010 -> flush count 1 one cycle later, SEL_PC reads 0x10; two consecutive redirects -> flush 2.
REQ-037 Redirect in last RUN cycle (limit=5) -> flush count 1 read in DONE.
REQ-038 Force cycle counter to 0xFFFF_FFFE, run 4 cycles -> reads 0xFFFF_FFFF.
REQ-039 rst_i low mid-RUN with pending flush -> all reads 0, state IDLE, running_o 0.
